// File: rtl/iir_stream_ctrl_if.sv
// Signal bundle between the IIR job controller and its surroundings:
// configuration, job control, sample source, filter side and result side.
interface iir_stream_ctrl_if #(
  parameter int NB    = 10,
  parameter int CNT_W = 10
);
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [NB-1:0]    cfg_data;
  logic             start;
  logic             abort;
  logic             src_valid;
  logic [NB-1:0]    src_data;
  logic             src_ready;
  logic [NB-1:0]    x;
  logic             vin;
  logic [NB-1:0]    b0;
  logic [NB-1:0]    b1;
  logic [NB-1:0]    a1;
  logic [NB-1:0]    y;
  logic             vout;
  logic [NB-1:0]    dout;
  logic             dvalid;
  logic [CNT_W-1:0] out_cnt;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  cfg_we, cfg_addr, cfg_data, start, abort, src_valid, src_data, y, vout,
    output src_ready, x, vin, b0, b1, a1, dout, dvalid, out_cnt, busy, done, err
  );

  modport slave (
    output cfg_we, cfg_addr, cfg_data, start, abort, src_valid, src_data, y, vout,
    input  src_ready, x, vin, b0, b1, a1, dout, dvalid, out_cnt, busy, done, err
  );
endinterface

// File: rtl/iir_stream_ctrl.sv
// Job sequencer in front of a single-pole IIR filter: shadow/active coefficients,
// bounded in-flight sample issue, output collection, completion and error reporting.
module iir_stream_ctrl #(
  parameter int NB       = 10,
  parameter int CNT_W    = 10,
  parameter int MAX_INFL = 4
) (
  input  logic              CLK_i,
  input  logic              RST_n_i,
  iir_stream_ctrl_if.master bus
);
  localparam int INFL_W = $clog2(MAX_INFL + 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   shadow_len_reg, len_reg, issued_reg, out_cnt_reg;
  logic [INFL_W-1:0]  infl_reg;
  logic [NB-1:0]      x_reg, dout_reg;
  logic               vin_reg, dvalid_reg, err_reg;
  logic [CNT_W-1:0]   cfg_len;
  logic [NB-1:0]      active_coef [3];
  logic               busy, src_ready, handshake, start_accept;
  logic               vout_stray, vout_taken, vout_ok;

  genvar gi;

  generate
    if (CNT_W <= NB) begin : g_len_trunc
      assign cfg_len = bus.cfg_data[CNT_W-1:0];
    end else begin : g_len_ext
      assign cfg_len = {{(CNT_W-NB){1'b0}}, bus.cfg_data};
    end
  endgenerate

  // Shadow coefficients are written any time; active ones only move in LOAD.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_coef
      logic [NB-1:0] shadow_reg, active_reg;
      always_ff @(posedge CLK_i or negedge RST_n_i) begin
        if (!RST_n_i) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (bus.cfg_we && bus.cfg_addr == 2'(gi))
            shadow_reg <= bus.cfg_data;
          if (state_reg == S_LOAD)
            active_reg <= shadow_reg;
        end
      end
      assign active_coef[gi] = active_reg;
    end
  endgenerate

  assign busy         = (state_reg != S_IDLE);
  assign start_accept = (state_reg == S_IDLE) && bus.start && (shadow_len_reg != '0);
  // A sample already on VIN is in flight even before infl_reg has counted it.
  assign src_ready    = (state_reg == S_RUN) && (issued_reg < len_reg) && !bus.abort &&
                        ((infl_reg + INFL_W'(vin_reg)) < INFL_W'(MAX_INFL));
  assign handshake    = bus.src_valid && src_ready;
  assign vout_stray   = bus.vout && (infl_reg == '0) && !vin_reg;
  assign vout_taken   = bus.vout && !vout_stray;
  assign vout_ok      = vout_taken && busy;

  always_ff @(posedge CLK_i or negedge RST_n_i) begin
    if (!RST_n_i)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_accept) state_next = S_LOAD;
      S_LOAD:  state_next = S_RUN;
      S_RUN:   if (bus.abort || (handshake && issued_reg == len_reg - 1'b1))
                 state_next = S_DRAIN;
      S_DRAIN: if (infl_reg == '0 && !vin_reg) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or negedge RST_n_i) begin
    if (!RST_n_i) begin
      shadow_len_reg <= '0;
      len_reg        <= '0;
      issued_reg     <= '0;
      infl_reg       <= '0;
      x_reg          <= '0;
      vin_reg        <= 1'b0;
      dout_reg       <= '0;
      dvalid_reg     <= 1'b0;
      out_cnt_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (bus.cfg_we && bus.cfg_addr == 2'd3)
        shadow_len_reg <= cfg_len;
      vin_reg <= handshake;
      if (handshake) begin
        x_reg      <= bus.src_data;
        issued_reg <= issued_reg + 1'b1;
      end
      infl_reg   <= infl_reg + INFL_W'(vin_reg) - INFL_W'(vout_taken);
      dvalid_reg <= vout_ok;
      if (vout_ok) begin
        dout_reg <= bus.y;
        if (out_cnt_reg != '1)
          out_cnt_reg <= out_cnt_reg + 1'b1;
      end
      if (start_accept) begin
        len_reg     <= shadow_len_reg;
        issued_reg  <= '0;
        out_cnt_reg <= '0;
        err_reg     <= 1'b0;
      end
      if (vout_stray)
        err_reg <= 1'b1;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.x         = x_reg;
  assign bus.vin       = vin_reg;
  assign bus.b0        = active_coef[0];
  assign bus.b1        = active_coef[1];
  assign bus.a1        = active_coef[2];
  assign bus.dout      = dout_reg;
  assign bus.dvalid    = dvalid_reg;
  assign bus.out_cnt   = out_cnt_reg;
  assign bus.busy      = busy;
  assign bus.done      = (state_reg == S_FIN);
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_iir_stream_ctrl.sv
// Randomised bench for iir_stream_ctrl: a latency-configurable filter stand-in,
// a patterned/random sample source and a job-level reference model.
module tb_iir_stream_ctrl;
  localparam int NB = 10, CNT_W = 10, MAX_INFL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iir_stream_ctrl_if #(.NB(NB), .CNT_W(CNT_W)) bus ();
  iir_stream_ctrl #(.NB(NB), .CNT_W(CNT_W), .MAX_INFL(MAX_INFL)) dut (
    .CLK_i(clk), .RST_n_i(rst_n), .bus(bus)
  );

  int n_cmp = 0, n_mis = 0;

  // Stimulus intents, consumed by the next cycle() call
  bit         start_req = 0, abort_req = 0, stray_req = 0, cfg_req = 0;
  logic [1:0] cfg_a = '0;
  logic [NB-1:0] cfg_d = '0;
  int lat = 2, src_mode = 0, phase = 0;
  bit src_en = 0;

  // Reference model state
  logic [NB-1:0] exp_x_q [$];
  logic          pipe_v [$];
  logic [NB-1:0] pipe_y [$];
  bit            hs_prev = 0, vout_ok_prev = 0, model_busy = 0;
  logic [NB-1:0] y_prev = '0;
  logic [NB-1:0] shadow [3], snap [3], exp_act [3];
  int shadow_len = 0, inflight = 0, peak = 0, acc_cnt = 0, done_cnt = 0, load_cd = 0, job_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_x_q.delete(); pipe_v.delete(); pipe_y.delete();
    hs_prev = 0; vout_ok_prev = 0; model_busy = 0; src_en = 0;
    inflight = 0; load_cd = 0; shadow_len = 0;
    for (int i = 0; i < 3; i++) begin shadow[i] = '0; snap[i] = '0; exp_act[i] = '0; end
  endtask

  // One clock: observe at the falling edge, then drive the next inputs.
  task automatic cycle();
    logic v;
    logic [NB-1:0] y;
    @(negedge clk);
    chk("vin", bus.vin, hs_prev);
    if (bus.vin) begin
      chk("x_pending", exp_x_q.size() > 0, 1);
      if (exp_x_q.size() > 0) chk("x", bus.x, exp_x_q.pop_front());
      inflight++;
      if (inflight > peak) peak = inflight;
      chk("infl_cap", inflight > MAX_INFL, 0);
    end
    chk("dvalid", bus.dvalid, vout_ok_prev);
    if (vout_ok_prev && bus.dvalid) chk("dout", bus.dout, y_prev);
    if (load_cd == 1) exp_act = snap;
    chk("coef", {bus.b0, bus.b1, bus.a1}, {exp_act[0], exp_act[1], exp_act[2]});
    if (load_cd == 2) snap = shadow;
    if (load_cd > 0) load_cd--;
    if (bus.done) begin
      done_cnt++;
      chk("done_infl", inflight, 0);
      model_busy = 0;
      src_en = 0;
    end
    // filter stand-in: fixed latency delay line
    pipe_v.push_back(bus.vin);
    pipe_y.push_back(NB'($urandom));
    v = 1'b0;
    y = NB'($urandom);
    vout_ok_prev = 0;
    if (pipe_v.size() >= lat) begin
      v = pipe_v.pop_front();
      y = pipe_y.pop_front();
    end
    if (v) begin inflight--; vout_ok_prev = 1; end
    if (stray_req) begin v = 1'b1; stray_req = 0; end
    bus.vout = v; bus.y = y; y_prev = y;
    // sample source
    if (src_en) begin
      case (src_mode)
        0: bus.src_valid = 1'b1;
        1: bus.src_valid = (phase % 3 == 0);
        default: bus.src_valid = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end else bus.src_valid = 1'b0;
    bus.src_data = NB'($urandom);
    // control and configuration
    bus.start = start_req;
    if (start_req && !model_busy && shadow_len != 0) begin
      model_busy = 1; load_cd = 2; src_en = 1; phase = 0; acc_cnt = 0; peak = 0;
      exp_x_q.delete();
    end
    start_req = 0;
    bus.abort = abort_req; abort_req = 0;
    bus.cfg_we = cfg_req; bus.cfg_addr = cfg_a; bus.cfg_data = cfg_d;
    if (cfg_req) begin
      if (cfg_a == 2'd3) shadow_len = int'(cfg_d);
      else shadow[cfg_a] = cfg_d;
    end
    cfg_req = 0;
    #1;
    hs_prev = bus.src_valid && bus.src_ready;
    if (hs_prev) begin exp_x_q.push_back(bus.src_data); acc_cnt++; end
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [NB-1:0] d);
    cfg_req = 1; cfg_a = a; cfg_d = d;
    cycle();
  endtask

  task automatic run_job(input int len, input int mode, input int abort_after,
                         input int latency, input bit mid_b0);
    int d0, guard, exp_acc;
    bit aborted, wrote;
    aborted = 0; wrote = 0;
    lat = latency; pipe_v.delete(); pipe_y.delete(); src_mode = mode;
    write_cfg(2'd3, NB'(len));
    d0 = done_cnt;
    start_req = 1;
    cycle();
    cycle();
    chk("busy_start", bus.busy, 1);
    chk("err_clr", bus.err, 0);
    guard = 0;
    while (done_cnt == d0 && guard < 400) begin
      if (abort_after > 0 && !aborted && acc_cnt >= abort_after) begin
        abort_req = 1; aborted = 1;
      end
      if (mid_b0 && !wrote && acc_cnt >= 1) begin
        cfg_req = 1; cfg_a = 2'd0; cfg_d = NB'(1); wrote = 1;
      end
      cycle();
      guard++;
    end
    chk("job_done", done_cnt - d0, 1);
    exp_acc = aborted ? abort_after : len;
    chk("accepted", acc_cnt, exp_acc);
    chk("out_cnt", bus.out_cnt, exp_acc);
    chk("done_busy", bus.busy, 1);
    cycle();
    chk("done_1cyc", bus.done, 0);
    chk("idle", bus.busy, 0);
    job_no++;
    $display("job %0d: len=%0d mode=%0d lat=%0d accepted=%0d out_cnt=%0d peak_infl=%0d",
             job_no, len, mode, latency, acc_cnt, bus.out_cnt, peak);
  endtask

  initial begin
    int d0, guard, len, ab;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.start = 0; bus.abort = 0;
    bus.src_valid = 0; bus.src_data = '0; bus.vout = 0; bus.y = '0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    chk("rst_flags", {bus.src_ready, bus.vin, bus.dvalid, bus.busy, bus.done, bus.err}, 0);
    chk("rst_x_dout", {bus.x, bus.dout}, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_coef", {bus.b0, bus.b1, bus.a1}, 0);

    // START with LEN=0 must be ignored
    start_req = 1;
    cycle();
    cycle();
    chk("len0_ignored", bus.busy, 0);

    write_cfg(2'd0, NB'('h0CB));
    write_cfg(2'd1, NB'('h0CB));
    write_cfg(2'd2, NB'('h39A));
    run_job(5, 0, 0, 2, 0);
    chk("coef_loaded", {bus.b0, bus.b1, bus.a1}, {10'h0CB, 10'h0CB, 10'h39A});
    run_job(12, 0, 0, 6, 0);
    chk("bp_peak", peak, MAX_INFL);
    run_job(3, 1, 0, 2, 0);
    run_job(8, 0, 2, 6, 0);
    run_job(6, 2, 0, 3, 1);
    chk("b0_held", bus.b0, 10'h0CB);
    run_job(4, 2, 0, 1, 0);
    chk("b0_new", bus.b0, 10'h001);

    // stray VOUT while idle
    stray_req = 1;
    cycle();
    cycle();
    chk("err_set", bus.err, 1);
    chk("stray_no_count", bus.out_cnt, 4);

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 3; c++) write_cfg(2'(c), NB'($urandom));
      len = $urandom_range(1, 20);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      run_job(len, $urandom_range(0, 2), ab, $urandom_range(1, 7), 0);
    end

    // reset in the middle of a running job
    write_cfg(2'd3, NB'(10));
    src_mode = 0; lat = 6; pipe_v.delete(); pipe_y.delete();
    start_req = 1;
    cycle();
    guard = 0;
    while (acc_cnt < 3 && guard < 50) begin cycle(); guard++; end
    chk("pre_rst_vin", bus.vin, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vin", bus.vin, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_coef", {bus.b0, bus.b1, bus.a1}, 0);
    model_reset();
    d0 = done_cnt;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("rst_no_done", done_cnt - d0, 0);

    write_cfg(2'd0, NB'('h011));
    write_cfg(2'd1, NB'('h022));
    write_cfg(2'd2, NB'('h033));
    run_job(3, 0, 0, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end
endmodule
